// File: rtl/rename_free_list.sv
// rename_free_list: circular pool of free rename registers with dual allocate, dual free
// and a single head checkpoint for rolling back speculative allocations.
module rename_free_list #(
   parameter int unsigned NUM_REN  = 32,
   parameter int unsigned REN_BASE = 32,
   parameter int unsigned REN_W    = 6
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic [1:0]                i_alloc_req,
   input  logic [1:0]                i_alloc_tag,
   output logic [1:0]                o_alloc_gnt,
   output logic [2*REN_W-1:0]        o_alloc_ren,
   input  logic [1:0]                i_free_we,
   input  logic [2*REN_W-1:0]        i_free_ren,
   input  logic                      i_delete_tagged,
   input  logic                      i_clear_tags,
   output logic [$clog2(NUM_REN):0]  o_free_count,
   output logic                      o_empty,
   output logic                      o_err
);
   localparam int unsigned IDX_W = $clog2(NUM_REN);
   localparam int unsigned PTR_W = IDX_W + 1;
   localparam logic [REN_W:0] REN_LO = (REN_W+1)'(REN_BASE);
   localparam logic [REN_W:0] REN_HI = (REN_W+1)'(REN_BASE + NUM_REN);

   logic [REN_W-1:0] r_mem [NUM_REN];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W-1:0] r_ckpt_head;
   logic             r_ckpt_valid;
   logic             r_err;

   logic [PTR_W-1:0] w_count;
   logic [PTR_W-1:0] w_head1;
   logic [PTR_W-1:0] w_head_d;
   logic [PTR_W-1:0] w_tail_d;
   logic [PTR_W-1:0] w_ckpt_head_d;
   logic [PTR_W-1:0] w_ckpt_at;
   logic             w_ckpt_valid_d;
   logic             w_err_d;
   logic [1:0]       w_gnt;
   logic [1:0]       w_tagged;
   logic [1:0]       w_wr;
   logic [PTR_W-1:0] w_wr_ptr [2];
   logic [REN_W-1:0] w_wr_ren [2];
   logic [REN_W-1:0] w_ren0;
   logic [REN_W-1:0] w_ren1;

   assign w_count = r_tail - r_head;
   assign w_head1 = r_head + PTR_W'(1);

   // Port 1 only sees the second entry when port 0 also asks, so it never takes a denied slot.
   always_comb begin
      w_gnt[0] = i_alloc_req[0] && (w_count >= PTR_W'(1)) && !i_delete_tagged;
      w_gnt[1] = i_alloc_req[1] && !i_delete_tagged &&
                 (w_count >= (i_alloc_req[0] ? PTR_W'(2) : PTR_W'(1)));
      w_ren0   = r_mem[r_head[IDX_W-1:0]];
      w_ren1   = i_alloc_req[0] ? r_mem[w_head1[IDX_W-1:0]] : w_ren0;
   end

   always_comb begin : free_path
      logic [PTR_W-1:0] occ;
      logic [REN_W-1:0] fren;
      w_tail_d = r_tail;
      w_err_d  = r_err;
      w_wr     = 2'b00;
      occ      = w_count;
      for (int i = 0; i < 2; i++) begin
         fren        = i_free_ren[i*REN_W +: REN_W];
         w_wr_ptr[i] = w_tail_d;
         w_wr_ren[i] = fren;
         if (i_free_we[i]) begin
            if (({1'b0, fren} >= REN_LO) && ({1'b0, fren} < REN_HI) &&
                (occ < PTR_W'(NUM_REN))) begin
               w_wr[i]  = 1'b1;
               w_tail_d = w_tail_d + PTR_W'(1);
               occ      = occ + PTR_W'(1);
            end else begin
               w_err_d = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_tagged       = w_gnt & i_alloc_tag;
      w_ckpt_at      = (!w_tagged[0] && w_gnt[0]) ? w_head1 : r_head;
      w_head_d       = r_head + PTR_W'(w_gnt[0]) + PTR_W'(w_gnt[1]);
      w_ckpt_head_d  = r_ckpt_head;
      w_ckpt_valid_d = r_ckpt_valid;
      if (i_delete_tagged) begin
         w_head_d       = r_ckpt_valid ? r_ckpt_head : r_head;
         w_ckpt_valid_d = 1'b0;
      end else if ((!r_ckpt_valid || i_clear_tags) && (|w_tagged)) begin
         w_ckpt_head_d  = w_ckpt_at;
         w_ckpt_valid_d = 1'b1;
      end else if (i_clear_tags) begin
         w_ckpt_valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_head       <= '0;
         r_tail       <= PTR_W'(NUM_REN);
         r_ckpt_head  <= '0;
         r_ckpt_valid <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_head       <= w_head_d;
         r_tail       <= w_tail_d;
         r_ckpt_head  <= w_ckpt_head_d;
         r_ckpt_valid <= w_ckpt_valid_d;
         r_err        <= w_err_d;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int k = 0; k < NUM_REN; k++) begin
            r_mem[k] <= REN_W'(REN_BASE + k);
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (w_wr[i]) begin
               r_mem[w_wr_ptr[i][IDX_W-1:0]] <= w_wr_ren[i];
            end
         end
      end
   end

   assign o_alloc_gnt  = w_gnt;
   assign o_alloc_ren  = {w_ren1, w_ren0};
   assign o_free_count = w_count;
   assign o_empty      = (w_count == '0);
   assign o_err        = r_err;

endmodule

// File: tb/tb_rename_free_list.sv
// Bench for rename_free_list: directed scenarios plus random traffic, checked against a
// queue-based model of the free pool, the in-flight registers and the speculative set.
module tb_rename_free_list;
   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [1:0]  i_alloc_req = '0;
   logic [1:0]  i_alloc_tag = '0;
   logic [1:0]  o_alloc_gnt;
   logic [11:0] o_alloc_ren;
   logic [1:0]  i_free_we = '0;
   logic [11:0] i_free_ren = '0;
   logic        i_delete_tagged = 1'b0;
   logic        i_clear_tags = 1'b0;
   logic [5:0]  o_free_count;
   logic        o_empty;
   logic        o_err;

   rename_free_list dut (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .i_alloc_req     (i_alloc_req),
      .i_alloc_tag     (i_alloc_tag),
      .o_alloc_gnt     (o_alloc_gnt),
      .o_alloc_ren     (o_alloc_ren),
      .i_free_we       (i_free_we),
      .i_free_ren      (i_free_ren),
      .i_delete_tagged (i_delete_tagged),
      .i_clear_tags    (i_clear_tags),
      .o_free_count    (o_free_count),
      .o_empty         (o_empty),
      .o_err           (o_err)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;

   // Model: free pool in allocation order, freeable registers, registers taken since checkpoint.
   int free_q[$];
   int safe_q[$];
   int spec_q[$];
   bit ckpt_v;
   bit err_m;

   logic [1:0] obs_gnt;
   logic [5:0] obs_ren0;
   logic [5:0] obs_ren1;
   logic [5:0] obs_count;
   logic       obs_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      free_q = {};
      safe_q = {};
      spec_q = {};
      for (int k = 0; k < 32; k++) free_q.push_back(32 + k);
      ckpt_v = 0;
      err_m  = 0;
   endtask

   function automatic int take_safe(input int idx);
      int r;
      r = safe_q[idx];
      safe_q.delete(idx);
      return r;
   endfunction

   // Called at a negedge; returns at the following negedge.
   task automatic step(input logic [1:0] req, input logic [1:0] tag, input logic del,
                       input logic clr, input logic [1:0] we, input logic [5:0] f0,
                       input logic [5:0] f1);
      int cnt;
      int acc;
      int r;
      int fr;
      logic [1:0] eg;
      i_alloc_req     = req;
      i_alloc_tag     = tag;
      i_delete_tagged = del;
      i_clear_tags    = clr;
      i_free_we       = we;
      i_free_ren      = {f1, f0};
      #1;
      cnt   = free_q.size();
      eg[0] = req[0] && cnt >= 1 && !del;
      eg[1] = req[1] && (req[0] ? cnt >= 2 : cnt >= 1) && !del;
      obs_gnt  = o_alloc_gnt;
      obs_ren0 = o_alloc_ren[5:0];
      obs_ren1 = o_alloc_ren[11:6];
      chk("gnt", 32'(obs_gnt), 32'(eg));
      if (eg[0]) chk("ren0", 32'(obs_ren0), free_q[0]);
      if (eg[1]) chk("ren1", 32'(obs_ren1), req[0] ? free_q[1] : free_q[0]);
      if (del) begin
         if (ckpt_v) free_q = {spec_q, free_q};
         spec_q = {};
         ckpt_v = 0;
      end else begin
         if (clr) begin
            safe_q = {safe_q, spec_q};
            spec_q = {};
            ckpt_v = 0;
         end
         for (int p = 0; p < 2; p++) begin
            if (eg[p]) begin
               if (tag[p]) ckpt_v = 1;
               r = free_q.pop_front();
               if (ckpt_v) spec_q.push_back(r);
               else safe_q.push_back(r);
            end
         end
      end
      acc = cnt;
      for (int p = 0; p < 2; p++) begin
         if (we[p]) begin
            fr = (p == 0) ? int'(f0) : int'(f1);
            if (fr >= 32 && fr < 64 && acc < 32) begin
               free_q.push_back(fr);
               acc++;
            end else begin
               err_m = 1;
            end
         end
      end
      @(posedge i_clk);
      #1;
      obs_count = o_free_count;
      obs_err   = o_err;
      chk("count", 32'(obs_count), free_q.size());
      chk("empty", 32'(o_empty), 32'(free_q.size() == 0));
      chk("err", 32'(obs_err), 32'(err_m));
      @(negedge i_clk);
   endtask

   task automatic do_reset();
      i_reset         = 1'b1;
      i_alloc_req     = '0;
      i_alloc_tag     = '0;
      i_free_we       = '0;
      i_delete_tagged = 1'b0;
      i_clear_tags    = 1'b0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;
      model_reset();
      chk("rst_count", 32'(o_free_count), 32);
      chk("rst_empty", 32'(o_empty), 0);
      chk("rst_err", 32'(o_err), 0);
   endtask

   initial begin
      logic [1:0] req, tag, we;
      logic       del, clr;
      logic [5:0] f0, f1;
      int a, b;

      // Release reset straight into a dual allocation.
      do_reset();
      step(2'b11, 2'b00, 0, 0, 2'b00, 6'd0, 6'd0);
      chk("t1_gnt", 32'(obs_gnt), 3);
      chk("t1_ren0", 32'(obs_ren0), 32);
      chk("t1_ren1", 32'(obs_ren1), 33);
      chk("t1_count", 32'(obs_count), 30);

      // Drain the pool, then a request on empty is refused.
      for (int i = 0; i < 15; i++) step(2'b11, 2'b00, 0, 0, 2'b00, 6'd0, 6'd0);
      chk("t2_empty", 32'(o_empty), 1);
      step(2'b11, 2'b00, 0, 0, 2'b00, 6'd0, 6'd0);
      chk("t2_gnt", 32'(obs_gnt), 0);

      // One entry left: dual request grants port 0 only; port-1-only request gets it.
      a = take_safe(0);
      step(2'b00, 2'b00, 0, 0, 2'b01, 6'(a), 6'd0);
      step(2'b11, 2'b00, 0, 0, 2'b00, 6'd0, 6'd0);
      chk("t3_gnt01", 32'(obs_gnt), 1);
      a = take_safe(0);
      step(2'b00, 2'b00, 0, 0, 2'b01, 6'(a), 6'd0);
      step(2'b10, 2'b00, 0, 0, 2'b00, 6'd0, 6'd0);
      chk("t3_gnt10", 32'(obs_gnt), 2);
      chk("t3_ren1", 32'(obs_ren1), 33);

      // Tagged allocations of 40..43 rolled back by delete_tagged.
      do_reset();
      for (int i = 0; i < 4; i++) step(2'b11, 2'b00, 0, 0, 2'b00, 6'd0, 6'd0);
      step(2'b11, 2'b11, 0, 0, 2'b00, 6'd0, 6'd0);
      step(2'b11, 2'b11, 0, 0, 2'b00, 6'd0, 6'd0);
      step(2'b00, 2'b00, 1, 0, 2'b00, 6'd0, 6'd0);
      chk("t4_count", 32'(obs_count), 24);
      step(2'b01, 2'b00, 0, 0, 2'b00, 6'd0, 6'd0);
      chk("t4_ren0", 32'(obs_ren0), 40);

      // Frees with a concurrent allocation, out-of-range free, overflow free.
      do_reset();
      step(2'b11, 2'b00, 0, 0, 2'b00, 6'd0, 6'd0);
      step(2'b00, 2'b00, 0, 0, 2'b10, 6'd0, 6'd7);
      chk("t5_err_range", 32'(obs_err), 1);
      chk("t5_count_range", 32'(obs_count), 30);
      a = take_safe(0);
      b = take_safe(0);
      step(2'b01, 2'b00, 0, 0, 2'b11, 6'(a), 6'(b));
      chk("t5_gnt", 32'(obs_gnt), 1);
      chk("t5_count", 32'(obs_count), 31);
      a = take_safe(0);
      step(2'b00, 2'b00, 0, 0, 2'b01, 6'(a), 6'd0);
      step(2'b00, 2'b00, 0, 0, 2'b01, 6'd40, 6'd0);
      chk("t5_count_ovf", 32'(obs_count), 32);

      // delete_tagged together with clear_tags still rolls back, and drops the checkpoint.
      do_reset();
      step(2'b11, 2'b00, 0, 0, 2'b00, 6'd0, 6'd0);
      step(2'b11, 2'b11, 0, 0, 2'b00, 6'd0, 6'd0);
      step(2'b01, 2'b01, 0, 0, 2'b00, 6'd0, 6'd0);
      step(2'b00, 2'b00, 1, 1, 2'b00, 6'd0, 6'd0);
      chk("t6_count", 32'(obs_count), 30);
      step(2'b01, 2'b00, 0, 0, 2'b00, 6'd0, 6'd0);
      chk("t6_ren0", 32'(obs_ren0), 34);
      step(2'b00, 2'b00, 1, 0, 2'b00, 6'd0, 6'd0);
      chk("t6_nockpt", 32'(obs_count), 29);

      // Random traffic with an asynchronous reset in the middle.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         req = 2'($urandom_range(0, 3));
         tag = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
         del = ($urandom_range(0, 15) == 0);
         clr = ($urandom_range(0, 9) == 0);
         we  = 2'b00;
         f0  = 6'($urandom_range(32, 63));
         f1  = 6'($urandom_range(32, 63));
         if (safe_q.size() > 0 && $urandom_range(0, 2) != 0) begin
            we[0] = 1'b1;
            f0 = 6'(take_safe($urandom_range(0, safe_q.size() - 1)));
         end else if ($urandom_range(0, 29) == 0) begin
            we[0] = 1'b1;
            f0 = 6'($urandom_range(0, 31));
         end
         if (safe_q.size() > 0 && $urandom_range(0, 2) == 0) begin
            we[1] = 1'b1;
            f1 = 6'(take_safe($urandom_range(0, safe_q.size() - 1)));
         end
         step(req, tag, del, clr, we, f0, f1);
         if (i == 300) begin
            i_alloc_req = 2'b11;
            #2;
            i_reset = 1'b1;
            #1;
            chk("mid_rst_count", 32'(o_free_count), 32);
            chk("mid_rst_err", 32'(o_err), 0);
            chk("mid_rst_ren0", 32'(o_alloc_ren[5:0]), 32);
            @(negedge i_clk);
            i_reset = 1'b0;
            model_reset();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
